exe_seq_driver: RTL and testbench
=================================

# exe_seq_driver

Command sequencer and result collector for the execution unit: the initiator side of the execution unit's operand/opcode interface. It accepts operation commands over a valid/ready handshake, buffers them in a small FIFO, and drives operands and opcode into the execution unit one command at a time. It captures each result and status word at the correct cycle and returns it over a second valid/ready handshake, keeping a saturating error counter. It sits between the test/host command source and the execution unit.

## Interface
- BITS, 8, operand/result width; must match the execution unit's BITS
- DEPTH, 4, command FIFO depth; power of two, ≥2
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock, reset is asynchronous and active-low
- in_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  FIFO can accept; equals !full
- in_cmd_a / in_cmd_b  in  BITS  operands
- in_cmd_op  in  2  opcode: 00 sub, 01 compare, 10 shift, 11 bit-change
- o_exe_a / o_exe_b  out  BITS  to execution unit in_a / in_b, registered
- o_exe_op  out  2  to execution unit i_op, registered
- in_exe_out  in  BITS  execution unit o_out
- in_exe_status  in  4  execution unit o_status
- o_res_valid  out  1  result available
- in_res_ready  in  1  consumer accepts result
- o_res_data  out  BITS  captured result
- o_res_status  out  4  captured status, bit order unchanged
- o_res_op  out  2  opcode that produced the result
- o_err_cnt  out  8  count of results with status ERROR bit set, saturating
- o_busy  out  1  high when state ≠ S_IDLE or FIFO non-empty

## Operation
- Push: in_cmd_valid && o_cmd_ready at a rising edge. When full, ready is low even if a pop occurs in the same cycle.
- FSM states: S_IDLE, S_ISSUE, S_CAPT, S_RESP.
- S_IDLE: if FIFO non-empty, pop the head into o_exe_a/b/op and go to S_ISSUE. Otherwise stay.
- S_ISSUE: o_exe_* hold the command, and the execution unit registers them at the end of this cycle. Next state is S_CAPT.
- S_CAPT: in_exe_out/in_exe_status are valid. Capture them and the opcode into the o_res_* registers. If the ERROR bit is set and o_err_cnt < 255, increment o_err_cnt. Next state is S_RESP.
- S_RESP: o_res_valid=1 and o_res_* are stable. On in_res_ready: if FIFO non-empty, pop into o_exe_* and go to S_ISSUE; else go to S_IDLE.
- o_exe_* hold their last issued value outside S_ISSUE.
- o_res_* hold their value after the handshake until the next capture.
- Status bit positions come from the shared macros include (OVF_BIT, ERROR_BIT, EVEN_BIT, SINGLE_BIT).
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

## Timing
- Reset (asynchronous): FIFO empty, state S_IDLE, all outputs 0 (o_cmd_ready=1 after release, o_res_valid=0, o_err_cnt=0).
- A reset mid-operation discards the in-flight command and all buffered commands immediately.
- A command accepted in cycle c gives: c+1 S_IDLE sees it; c+2 S_ISSUE; c+3 S_CAPT; c+4 o_res_valid=1.
- Back-to-back with in_res_ready held high: one result every 3 cycles (RESP→ISSUE→CAPT→RESP).
- Consumer stall: the FSM stays in S_RESP. The FIFO keeps accepting until full.
- A push into an empty FIFO is not visible to the FSM until the next cycle (no bypass).

## Structure
- Shared package exe_pkg:
  - op enum: OP_SUB=2'b00, OP_CMP=2'b01, OP_SHL=2'b10, OP_CHG=2'b11
  - drv_state_t enum for the FSM states
  - EXE_STATUS_W=4
- Sub-module exe_cmd_fifo (parameters W, DEPTH; push/pop/full/empty/head).
- Top: FSM, result registers, error counter.

## Test plan
Bench uses an execution-unit stub with registered inputs: out = a+b, status = {ERROR=(op==11), others 0}.
- Reset, then single cmd a=8'h05, b=8'h03, op=00 accepted in cycle c -> o_res_valid rises in c+4; o_res_data=8'h08, o_res_op=00, o_err_cnt=0.
- 4 cmds pushed on consecutive cycles with in_res_ready=1 -> the 5th offer sees o_cmd_ready=0 only if no pop has freed space; results emerge in order, spaced 3 cycles apart.
- in_res_ready=0 for 20 cycles after the first result -> o_res_* stable; FIFO fills to DEPTH and o_cmd_ready=0; releasing ready drains every entry in order.
- 300 commands with op=11 -> o_err_cnt saturates at 255 and stays there.
- Assert i_rst low during S_CAPT with 2 cmds queued -> o_res_valid, o_busy and o_exe_* drop to 0 without waiting for a clock edge. After release no stale result appears, and o_cmd_ready=1.
- Push while full in the same cycle as a pop (S_RESP handshake) -> push not accepted; the command must be re-offered next cycle.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types and constants for the execution-unit sequencer and its neighbours.
// Status bit positions must agree with the execution unit's status word.
package exe_pkg;

    localparam int EXE_STATUS_W = 4;

    localparam int OVF_BIT    = 0;
    localparam int ERROR_BIT  = 1;
    localparam int EVEN_BIT   = 2;
    localparam int SINGLE_BIT = 3;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_CMP = 2'b01,
        OP_SHL = 2'b10,
        OP_CHG = 2'b11
    } exe_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_RESP
    } drv_state_t;

endpackage

// File: rtl/exe_cmd_fifo.sv
// Small command FIFO for the sequencer: registered pointers and occupancy count.
// The head is read combinationally from storage; a push into an empty FIFO shows up one cycle later.
module exe_cmd_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [W-1:0]  mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries counted as valid are ever read.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/exe_seq_driver.sv
// Command sequencer for the execution unit: issues buffered commands one at a time,
// captures result/status two cycles after issue and hands them out with a saturating error count.
module exe_seq_driver
    import exe_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    in_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [BITS-1:0]         in_cmd_a,
    input  logic [BITS-1:0]         in_cmd_b,
    input  logic [1:0]              in_cmd_op,
    output logic [BITS-1:0]         o_exe_a,
    output logic [BITS-1:0]         o_exe_b,
    output logic [1:0]              o_exe_op,
    input  logic [BITS-1:0]         in_exe_out,
    input  logic [EXE_STATUS_W-1:0] in_exe_status,
    output logic                    o_res_valid,
    input  logic                    in_res_ready,
    output logic [BITS-1:0]         o_res_data,
    output logic [EXE_STATUS_W-1:0] o_res_status,
    output logic [1:0]              o_res_op,
    output logic [7:0]              o_err_cnt,
    output logic                    o_busy
);

    localparam int CW = 2*BITS + 2;

    drv_state_t      state;
    drv_state_t      state_nxt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [CW-1:0]   fifo_head;

    assign o_cmd_ready = !fifo_full;
    assign o_res_valid = (state == S_RESP);
    assign o_busy      = (state != S_IDLE) || !fifo_empty;

    exe_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push    (in_cmd_valid),
        .wr_data ({in_cmd_op, in_cmd_b, in_cmd_a}),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_RESP;
            S_RESP: begin
                if (in_res_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands only change on a pop, so they hold through CAPT/RESP/IDLE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_exe_a  <= '0;
            o_exe_b  <= '0;
            o_exe_op <= '0;
        end else if (fifo_pop) begin
            {o_exe_op, o_exe_b, o_exe_a} <= fifo_head;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_res_data   <= '0;
            o_res_status <= '0;
            o_res_op     <= '0;
            o_err_cnt    <= '0;
        end else if (state == S_CAPT) begin
            o_res_data   <= in_exe_out;
            o_res_status <= in_exe_status;
            o_res_op     <= o_exe_op;
            if (in_exe_status[ERROR_BIT] && (o_err_cnt != 8'hFF))
                o_err_cnt <= o_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_exe_seq_driver.sv
// Self-checking bench for exe_seq_driver: randomized commands against a queue-based result model,
// with a registered execution-unit stub computing a+b and flagging ERROR for op 11.
module tb_exe_seq_driver;
    import exe_pkg::*;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic            in_cmd_valid = 1'b0;
    logic            o_cmd_ready;
    logic [BITS-1:0] in_cmd_a = '0;
    logic [BITS-1:0] in_cmd_b = '0;
    logic [1:0]      in_cmd_op = '0;
    logic [BITS-1:0] o_exe_a;
    logic [BITS-1:0] o_exe_b;
    logic [1:0]      o_exe_op;
    logic [BITS-1:0] in_exe_out;
    logic [3:0]      in_exe_status;
    logic            o_res_valid;
    logic            in_res_ready = 1'b0;
    logic [BITS-1:0] o_res_data;
    logic [3:0]      o_res_status;
    logic [1:0]      o_res_op;
    logic [7:0]      o_err_cnt;
    logic            o_busy;

    exe_seq_driver #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .in_cmd_valid  (in_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .in_cmd_a      (in_cmd_a),
        .in_cmd_b      (in_cmd_b),
        .in_cmd_op     (in_cmd_op),
        .o_exe_a       (o_exe_a),
        .o_exe_b       (o_exe_b),
        .o_exe_op      (o_exe_op),
        .in_exe_out    (in_exe_out),
        .in_exe_status (in_exe_status),
        .o_res_valid   (o_res_valid),
        .in_res_ready  (in_res_ready),
        .o_res_data    (o_res_data),
        .o_res_status  (o_res_status),
        .o_res_op      (o_res_op),
        .o_err_cnt     (o_err_cnt),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Execution-unit stub: operands registered on the clock, result combinational from them.
    logic [BITS-1:0] stub_a = '0;
    logic [BITS-1:0] stub_b = '0;
    logic [1:0]      stub_op = '0;
    always @(posedge i_clk) begin
        stub_a  <= o_exe_a;
        stub_b  <= o_exe_b;
        stub_op <= o_exe_op;
    end
    assign in_exe_out    = stub_a + stub_b;
    assign in_exe_status = (stub_op == 2'b11) ? 4'(1 << ERROR_BIT) : 4'b0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] status;
        logic [1:0] op;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_hs = -1;
    int         exp_err = 0;
    bit         check_gap = 0;
    bit         stall_prev = 0;
    logic [7:0] held_data;
    logic [3:0] held_status;
    logic [1:0] held_op;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // One clock cycle: check the result port at the negedge, then drive this cycle's inputs.
    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] op, input logic rr, output bit acc);
        exp_t e;
        @(negedge i_clk);
        cyc++;
        in_res_ready = rr;
        if (o_res_valid) begin
            if (stall_prev) begin
                checkOutput("hold_data", o_res_data, held_data);
                checkOutput("hold_status", o_res_status, held_status);
                checkOutput("hold_op", o_res_op, held_op);
            end
            if (rr) begin
                checkOutput("result_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e.status[ERROR_BIT] && exp_err < 255) exp_err++;
                    checkOutput("res_data", o_res_data, e.data);
                    checkOutput("res_status", o_res_status, e.status);
                    checkOutput("res_op", o_res_op, e.op);
                    checkOutput("err_cnt", o_err_cnt, exp_err);
                    if (check_gap && last_hs >= 0) checkOutput("result_gap", cyc - last_hs, 3);
                    last_hs = cyc;
                end
                stall_prev = 0;
            end else begin
                stall_prev  = 1;
                held_data   = o_res_data;
                held_status = o_res_status;
                held_op     = o_res_op;
            end
        end else begin
            stall_prev = 0;
        end
        in_cmd_valid = v;
        in_cmd_a     = a;
        in_cmd_b     = b;
        in_cmd_op    = op;
        acc = v && o_cmd_ready;
        if (acc) begin
            e.data   = 8'(a + b);
            e.status = (op == 2'b11) ? 4'(1 << ERROR_BIT) : 4'b0;
            e.op     = op;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while ((exp_q.size() > 0 || o_busy) && n < 300) begin
            applyStimulus(1'b0, 8'h0, 8'h0, 2'b00, 1'b1, acc);
            n++;
        end
        checkOutput("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        int lat;
        int cnt;
        int sent;
        int guard;

        // Reset state while held in reset
        #1;
        checkOutput("rst_res_valid", o_res_valid, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_err_cnt", o_err_cnt, 0);
        checkOutput("rst_exe", {o_exe_op, o_exe_b, o_exe_a}, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        checkOutput("rst_cmd_ready", o_cmd_ready, 1);

        // Single command latency
        applyStimulus(1'b1, 8'h05, 8'h03, 2'b00, 1'b1, acc);
        checkOutput("single_accept", acc, 1);
        lat = 0;
        do begin
            applyStimulus(1'b0, 8'h0, 8'h0, 2'b00, 1'b1, acc);
            lat++;
        end while (!o_res_valid && lat < 10);
        checkOutput("single_latency", lat, 4);
        checkOutput("single_data", o_res_data, 8'h08);
        checkOutput("single_op", o_res_op, 2'b00);
        checkOutput("single_err", o_err_cnt, 0);
        drain();

        // Back-to-back burst with the consumer always ready
        check_gap = 1;
        last_hs   = -1;
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, acc);
        drain();
        check_gap = 0;

        // Consumer stall: FIFO fills, then push-while-full during the releasing pop
        applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, acc);
        lat = 0;
        do begin
            applyStimulus(1'b0, 8'h0, 8'h0, 2'b00, 1'b0, acc);
            lat++;
        end while (!o_res_valid && lat < 10);
        checkOutput("stall_first_valid", o_res_valid, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, acc);
            cnt += int'(acc);
        end
        checkOutput("stall_accepts", cnt, DEPTH);
        checkOutput("stall_ready_low", o_cmd_ready, 0);
        applyStimulus(1'b1, 8'h11, 8'h22, 2'b01, 1'b1, acc);
        checkOutput("push_while_full", acc, 0);
        applyStimulus(1'b1, 8'h11, 8'h22, 2'b01, 1'b1, acc);
        checkOutput("reoffer_accepted", acc, 1);
        drain();

        // Random mixed traffic
        for (int i = 0; i < 80; i++)
            applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                          1'($urandom_range(0, 3) != 0), acc);
        drain();

        // Error counter saturation
        sent  = 0;
        guard = 0;
        while (sent < 300 && guard < 5000) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'b11,
                          1'($urandom_range(0, 3) != 0), acc);
            sent += int'(acc);
            guard++;
        end
        checkOutput("sat_sent", sent, 300);
        drain();
        checkOutput("err_saturated", o_err_cnt, 255);
        applyStimulus(1'b1, 8'h01, 8'h01, 2'b11, 1'b1, acc);
        drain();
        checkOutput("err_stays_saturated", o_err_cnt, 255);

        // Asynchronous reset during capture with two commands queued
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, acc);
        @(negedge i_clk);
        in_cmd_valid = 1'b0;
        checkOutput("pre_rst_busy", o_busy, 1);
        #1;
        i_rst = 1'b0;
        #1;
        checkOutput("arst_res_valid", o_res_valid, 0);
        checkOutput("arst_busy", o_busy, 0);
        checkOutput("arst_exe", {o_exe_op, o_exe_b, o_exe_a}, 0);
        checkOutput("arst_err_cnt", o_err_cnt, 0);
        exp_q.delete();
        exp_err    = 0;
        stall_prev = 0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        checkOutput("post_rst_ready", o_cmd_ready, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h0, 8'h0, 2'b00, 1'b1, acc);
            checkOutput("no_stale_result", o_res_valid, 0);
        end
        checkOutput("post_rst_idle", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
